// File: rtl/wb_select_stage.sv
// ============================================================================
// Module   : wb_select_stage
// Purpose  : MEM/WB latch with writeback source select and load extraction.
//            Optional retire counter enabled by defining WB_RETIRE_CNT_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module wb_select_stage #(
    parameter int DATA_W     = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic                  stall,
    input  logic                  flush,
    input  logic [1:0]            wb_sel,
    input  logic [DATA_W-1:0]     alu_out,
    input  logic [DATA_W-1:0]     dm_out,
    input  logic [DATA_W-1:0]     pc_plus4,
    input  logic [DATA_W-1:0]     imm,
    input  logic [1:0]            ld_size,
    input  logic                  ld_unsigned,
    input  logic [1:0]            byte_off,
    input  logic [REG_ADDR_W-1:0] rd,
    input  logic                  rf_we,
`ifdef WB_RETIRE_CNT_EN
    output logic [31:0]           retire_cnt,
`endif
    output logic                  wb_valid,
    output logic                  wb_we,
    output logic [REG_ADDR_W-1:0] wb_rd,
    output logic [DATA_W-1:0]     wb_data,
    output logic                  misalign_err
);

    localparam logic [1:0] c_SEL_ALU = 2'b00;
    localparam logic [1:0] c_SEL_DM  = 2'b01;
    localparam logic [1:0] c_SEL_PC  = 2'b10;
    localparam logic [1:0] c_SZ_BYTE = 2'b00;
    localparam logic [1:0] c_SZ_HALF = 2'b01;

    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_word;
    logic              w_sext;
    logic [DATA_W-1:0] w_ld_val;
    logic [DATA_W-1:0] w_wb_val;
    logic              w_misalign;
    logic              w_we_next;

    assign w_byte = dm_out[{byte_off, 3'b000} +: 8];
    assign w_half = dm_out[{byte_off[1], 4'b0000} +: 16];
    assign w_word = dm_out[31:0];

    // Load-size encoding 11 behaves as a word load.
    always_comb begin
        w_ld_val = '0;
        w_sext   = 1'b0;
        if (ld_size == c_SZ_BYTE) begin
            w_sext   = ~ld_unsigned & w_byte[7];
            w_ld_val = {{(DATA_W-8){w_sext}}, w_byte};
        end else if (ld_size == c_SZ_HALF) begin
            w_sext   = ~ld_unsigned & w_half[15];
            w_ld_val = {{(DATA_W-16){w_sext}}, w_half};
        end else begin
            w_sext   = ~ld_unsigned & w_word[31];
            w_ld_val = {{(DATA_W-32){w_sext}}, w_word};
        end
    end

    always_comb begin
        w_wb_val = imm;
        case (wb_sel)
            c_SEL_ALU: w_wb_val = alu_out;
            c_SEL_DM:  w_wb_val = w_ld_val;
            c_SEL_PC:  w_wb_val = pc_plus4;
            default:   w_wb_val = imm;
        endcase
    end

    assign w_misalign = (wb_sel == c_SEL_DM) &
                        (((ld_size == c_SZ_HALF) & byte_off[0]) |
                         (ld_size[1] & (byte_off != 2'b00)));

    assign w_we_next = in_valid & rf_we & (rd != '0) & ~w_misalign;

    // Flush clears the control bits only; rd/data keep their last value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            wb_rd        <= '0;
            wb_data      <= '0;
            misalign_err <= 1'b0;
        end else if (flush) begin
            wb_valid     <= 1'b0;
            wb_we        <= 1'b0;
            misalign_err <= 1'b0;
        end else if (!stall) begin
            wb_valid     <= in_valid;
            wb_we        <= w_we_next;
            wb_rd        <= rd;
            wb_data      <= w_wb_val;
            misalign_err <= in_valid & w_misalign;
        end
    end

`ifdef WB_RETIRE_CNT_EN
    logic [31:0] r_retire_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_retire_cnt <= '0;
        end else if (!flush && !stall && in_valid) begin
            r_retire_cnt <= r_retire_cnt + 32'd1;
        end
    end

    assign retire_cnt = r_retire_cnt;
`endif

endmodule

`default_nettype wire
